// File: rtl/cpu_exec_seq_if.sv
// Shared-bus request/response bundle between the execution sequencer and cpu_bus_ctrl.
// The sequencer is the master: it owns address, size, data and the read/write strobes.
interface cpu_exec_seq_if;
    logic [31:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [1:0]  bus_wlen;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_addr, bus_rd, bus_wr, bus_wlen, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_addr, bus_rd, bus_wr, bus_wlen, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/cpu_exec_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 execution unit.
// Sole owner of pc and the bus request strobes; any fault parks it in TRAP until clr.
module cpu_exec_seq #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    cpu_exec_seq_if.master bus,
    output logic [31:0] ir,
    input  logic        dec_valid,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_branch,
    input  logic        dec_is_jal,
    input  logic        dec_is_jalr,
    input  logic [1:0]  dec_ls_size,
    input  logic [31:0] dec_imm,
    input  logic [31:0] rs2_dat,
    output logic        alu_start,
    input  logic        alu_ready,
    input  logic [31:0] alu_result,
    input  logic        br_taken,
    output logic        greg_wen,
    output logic [31:0] greg_wdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [7:0]  TMO_LIMIT = 8'(BUS_TIMEOUT);
    localparam logic [31:0] IR_NOP    = 32'h0000_0013;

    state_t      state, state_nx;
    logic [1:0]  cause_nx;
    logic [7:0]  tmo_cnt, tmo_inc;
    logic        tmo_hit;
    logic [31:0] addr_q, ld_q, pc_nx, bus_addr_c;
    logic        br_q, alu_busy;
    logic        req_rd, req_wr;
    logic [1:0]  wlen_c;
    logic        ir_ld, ex_ld, ld_ld, pc_ld;
    logic        is_ls, ls_misaligned;

    assign is_ls   = dec_is_load | dec_is_store;
    assign tmo_inc = tmo_cnt + 8'd1;
    assign tmo_hit = (tmo_inc == TMO_LIMIT);

    always_comb begin
        ls_misaligned = 1'b0;
        if (dec_ls_size == 2'b01)
            ls_misaligned = alu_result[0];
        else if (dec_ls_size[1])
            ls_misaligned = (alu_result[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= S_FETCH;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        cause_nx   = trap_cause;
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        bus_addr_c = pc;
        wlen_c     = 2'b10;
        alu_start  = 1'b0;
        greg_wen   = 1'b0;
        greg_wdata = addr_q;
        retire     = 1'b0;
        ir_ld      = 1'b0;
        ex_ld      = 1'b0;
        ld_ld      = 1'b0;
        pc_ld      = 1'b0;
        case (state)
            S_FETCH: begin
                if (!stall) begin
                    if (pc[1:0] != 2'b00) begin
                        state_nx = S_TRAP;
                        cause_nx = 2'd3;
                    end else begin
                        req_rd = 1'b1;
                        if (bus.bus_ready) begin
                            ir_ld    = 1'b1;
                            state_nx = S_DECODE;
                        end else if (tmo_hit) begin
                            state_nx = S_TRAP;
                            cause_nx = 2'd2;
                        end
                    end
                end
            end
            S_DECODE: begin
                if (!dec_valid) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'd1;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_start = !alu_busy;
                if (alu_ready) begin
                    ex_ld = 1'b1;
                    if (is_ls && ls_misaligned) begin
                        state_nx = S_TRAP;
                        cause_nx = 2'd3;
                    end else if (is_ls) begin
                        state_nx = S_MEM;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_MEM: begin
                bus_addr_c = addr_q;
                wlen_c     = dec_ls_size;
                req_rd     = dec_is_load;
                req_wr     = dec_is_store;
                if (bus.bus_ready) begin
                    ld_ld    = dec_is_load;
                    state_nx = S_WB;
                end else if (tmo_hit) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'd2;
                end
            end
            S_WB: begin
                retire   = 1'b1;
                greg_wen = !(dec_is_store || dec_is_branch);
                if (dec_is_load)
                    greg_wdata = ld_q;
                else if (dec_is_jal || dec_is_jalr)
                    greg_wdata = pc + 32'd4;
                pc_ld    = 1'b1;
                state_nx = S_FETCH;
            end
            default: ;
        endcase
    end

    always_comb begin
        if ((dec_is_branch && br_q) || dec_is_jal)
            pc_nx = pc + dec_imm;
        else if (dec_is_jalr)
            pc_nx = {addr_q[31:1], 1'b0};
        else
            pc_nx = pc + 32'd4;
    end

    // Counter only runs while a request is outstanding, so it is zero on every FETCH/MEM entry.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc         <= RESET_PC;
            ir         <= IR_NOP;
            trap_cause <= '0;
            tmo_cnt    <= '0;
            addr_q     <= '0;
            ld_q       <= '0;
            br_q       <= 1'b0;
            alu_busy   <= 1'b0;
        end else begin
            trap_cause <= cause_nx;
            alu_busy   <= (state == S_EXEC);
            if ((req_rd || req_wr) && !bus.bus_ready)
                tmo_cnt <= tmo_inc;
            else
                tmo_cnt <= '0;
            if (ir_ld)
                ir <= bus.bus_rdata;
            if (ex_ld) begin
                addr_q <= alu_result;
                br_q   <= br_taken;
            end
            if (ld_ld)
                ld_q <= bus.bus_rdata;
            if (pc_ld)
                pc <= pc_nx;
        end
    end

    // Strobes are masked by clr so a reset mid-access drops the request without waiting for a clock.
    assign bus.bus_rd    = req_rd & ~clr;
    assign bus.bus_wr    = req_wr & ~clr;
    assign bus.bus_addr  = bus_addr_c;
    assign bus.bus_wlen  = wlen_c;
    assign bus.bus_wdata = rs2_dat;
    assign trap          = (state == S_TRAP);

endmodule

// File: tb/tb_cpu_exec_seq.sv
// Self-checking bench for cpu_exec_seq: scripted bus/decoder/ALU responders plus an
// instruction-level model of pc, writeback and trap behaviour.
module tb_cpu_exec_seq;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned TMO    = 4;
    localparam int unsigned K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5;

    typedef struct {
        int unsigned kind;
        bit          valid;
        int unsigned fwait, awt, mwait;
        logic [1:0]  sz;
        logic [31:0] res, imm, rdat, rs2;
        bit          taken;
        bit          abort_mem;
    } instr_t;

    logic        clk = 1'b0;
    logic        clr, stall;
    logic [31:0] ir;
    logic        dec_valid, dec_is_load, dec_is_store, dec_is_branch, dec_is_jal, dec_is_jalr;
    logic [1:0]  dec_ls_size;
    logic [31:0] dec_imm, rs2_dat, alu_result, greg_wdata, pc;
    logic        alu_start, alu_ready, br_taken, greg_wen, retire, trap;
    logic [1:0]  trap_cause;

    cpu_exec_seq_if bus();

    cpu_exec_seq #(.RESET_PC(RST_PC), .BUS_TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr), .stall(stall), .bus(bus), .ir(ir),
        .dec_valid(dec_valid), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_branch(dec_is_branch), .dec_is_jal(dec_is_jal), .dec_is_jalr(dec_is_jalr),
        .dec_ls_size(dec_ls_size), .dec_imm(dec_imm), .rs2_dat(rs2_dat),
        .alu_start(alu_start), .alu_ready(alu_ready), .alu_result(alu_result), .br_taken(br_taken),
        .greg_wen(greg_wen), .greg_wdata(greg_wdata), .pc(pc), .retire(retire),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] pc_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] strb();
        return {27'd0, bus.bus_rd, bus.bus_wr, alu_start, greg_wen, retire};
    endfunction

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic instr_t mk(input int unsigned kind, input logic [31:0] res, input logic [31:0] imm);
        instr_t d;
        d.kind = kind; d.valid = 1'b1; d.fwait = 0; d.awt = 0; d.mwait = 0; d.sz = 2'd2;
        d.res = res; d.imm = imm; d.rdat = $urandom; d.rs2 = $urandom; d.taken = 1'b0;
        d.abort_mem = 1'b0;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1; stall = 1'b0; bus.bus_ready = 1'b0; alu_ready = 1'b0;
        #2;
        check("rst_strobes", strb(), 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_trap", {30'd0, trap, trap_cause}, 32'd0);
        @(posedge clk);
        #1;
        clr  = 1'b0;
        pc_m = RST_PC;
    endtask

    task automatic expect_trap(input logic [1:0] cause);
        for (int i = 0; i < 2; i++) begin
            bus.bus_ready = 1'($urandom);
            alu_ready     = 1'($urandom);
            @(negedge clk);
            check("trap_state", {29'd0, trap, trap_cause}, {29'd0, 1'b1, cause});
            check("trap_strobes", strb(), 32'd0);
            check("trap_pc", pc, pc_m);
            tick();
        end
    endtask

    task automatic run_instr(input instr_t d, output bit trapped);
        logic [31:0] iw, exp_wd;
        bit is_ld, is_st, is_ls, wen;
        trapped = 1'b0;
        iw    = $urandom;
        is_ld = (d.kind == K_LOAD);
        is_st = (d.kind == K_STORE);
        is_ls = is_ld || is_st;
        dec_valid = d.valid; dec_is_load = is_ld; dec_is_store = is_st;
        dec_is_branch = (d.kind == K_BR); dec_is_jal = (d.kind == K_JAL);
        dec_is_jalr = (d.kind == K_JALR); dec_ls_size = d.sz; dec_imm = d.imm;
        rs2_dat = d.rs2; alu_result = d.res; br_taken = d.taken;
        bus.bus_ready = 1'b0; alu_ready = 1'b0;
        if (pc_m % 4 != 0) begin
            @(negedge clk);
            check("misfetch_strobes", strb(), 32'd0);
            tick();
            expect_trap(2'd3);
            trapped = 1'b1;
            return;
        end
        for (int i = 0; i <= int'(d.fwait); i++) begin
            bus.bus_ready = (i == int'(d.fwait));
            bus.bus_rdata = (i == int'(d.fwait)) ? iw : $urandom;
            @(negedge clk);
            check("fetch_strobes", strb(), 32'b10000);
            check("fetch_addr", bus.bus_addr, pc_m);
            check("fetch_wlen", {30'd0, bus.bus_wlen}, 32'd2);
            check("pc", pc, pc_m);
            tick();
        end
        bus.bus_ready = 1'b0;
        @(negedge clk);
        check("decode_ir", ir, iw);
        check("decode_strobes", strb(), 32'd0);
        tick();
        if (!d.valid) begin
            expect_trap(2'd1);
            trapped = 1'b1;
            return;
        end
        for (int i = 0; i <= int'(d.awt); i++) begin
            alu_ready = (i == int'(d.awt));
            @(negedge clk);
            check("exec_strobes", strb(), {29'd0, (i == 0), 2'b00});
            tick();
        end
        alu_ready = 1'b0;
        if (is_ls && misal(d.sz, d.res)) begin
            expect_trap(2'd3);
            trapped = 1'b1;
            return;
        end
        if (is_ls) begin
            for (int i = 0; i <= int'(d.mwait); i++) begin
                bus.bus_ready = (i == int'(d.mwait));
                bus.bus_rdata = (i == int'(d.mwait)) ? d.rdat : $urandom;
                @(negedge clk);
                check("mem_strobes", strb(), {27'd0, is_ld, is_st, 3'b000});
                check("mem_addr", bus.bus_addr, d.res);
                check("mem_wlen", {30'd0, bus.bus_wlen}, {30'd0, d.sz});
                if (is_st)
                    check("mem_wdata", bus.bus_wdata, d.rs2);
                if (d.abort_mem) begin
                    #1 clr = 1'b1;
                    #1;
                    check("clr_mem_strobes", strb(), 32'd0);
                    check("clr_mem_pc", pc, RST_PC);
                    trapped = 1'b1;
                    return;
                end
                tick();
            end
            bus.bus_ready = 1'b0;
        end
        if (is_ld)
            exp_wd = d.rdat;
        else if (d.kind == K_JAL || d.kind == K_JALR)
            exp_wd = pc_m + 32'd4;
        else
            exp_wd = d.res;
        wen = !(is_st || d.kind == K_BR);
        @(negedge clk);
        check("wb_strobes", strb(), {27'd0, 3'b000, wen, 1'b1});
        check("wb_pc", pc, pc_m);
        if (wen)
            check("wb_wdata", greg_wdata, exp_wd);
        tick();
        if ((d.kind == K_BR && d.taken) || d.kind == K_JAL)
            pc_m = pc_m + d.imm;
        else if (d.kind == K_JALR)
            pc_m = d.res - (d.res % 2);
        else
            pc_m = pc_m + 32'd4;
    endtask

    initial begin
        instr_t d;
        bit tr;
        clr = 1'b1; stall = 1'b0; bus.bus_ready = 1'b0; bus.bus_rdata = '0;
        dec_valid = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_branch = 1'b0;
        dec_is_jal = 1'b0; dec_is_jalr = 1'b0; dec_ls_size = '0; dec_imm = '0;
        rs2_dat = '0; alu_ready = 1'b0; alu_result = '0; br_taken = 1'b0;
        do_reset();

        d = mk(K_ALU, 32'h0000_1234, '0);                       run_instr(d, tr);
        d = mk(K_LOAD, 32'h100, '0); d.mwait = 3; d.rdat = 32'hDEAD_BEEF; run_instr(d, tr);
        d = mk(K_JAL, '0, 32'h18); d.fwait = 3;                 run_instr(d, tr);
        d = mk(K_BR, '0, 32'hFFFF_FFF8); d.taken = 1'b1;        run_instr(d, tr);
        d = mk(K_BR, '0, 32'h40); d.awt = 2;                    run_instr(d, tr);
        d = mk(K_JALR, 32'h41, '0);                             run_instr(d, tr);
        d = mk(K_STORE, 32'h202, '0); d.sz = 2'd1; d.mwait = 1; run_instr(d, tr);

        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_strobes", strb(), 32'd0);
            check("stall_pc", pc, pc_m);
            tick();
        end
        stall = 1'b0;
        d = mk(K_ALU, 32'h5, '0); d.fwait = 3;                  run_instr(d, tr);

        d = mk(K_JALR, 32'hFFFF_FFFC, '0);                      run_instr(d, tr);
        d = mk(K_ALU, 32'h7, '0);                               run_instr(d, tr);
        check("pc_wrap_model", pc_m, 32'd0);

        d = mk(K_JALR, 32'h42, '0);                             run_instr(d, tr);
        d = mk(K_ALU, 32'h0, '0);                               run_instr(d, tr);
        do_reset();

        d = mk(K_ALU, 32'h0, '0); d.valid = 1'b0;               run_instr(d, tr);
        do_reset();

        d = mk(K_STORE, 32'h103, '0); d.sz = 2'd1;              run_instr(d, tr);
        do_reset();

        bus.bus_ready = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            @(negedge clk);
            check("tmo_strobes", strb(), 32'b10000);
            tick();
        end
        expect_trap(2'd2);
        do_reset();

        d = mk(K_STORE, 32'h200, '0); d.mwait = 2; d.abort_mem = 1'b1; run_instr(d, tr);
        do_reset();

        repeat (150) begin
            d = mk($urandom_range(0, 5), $urandom, $urandom & 32'hFFFF_FFFC);
            d.valid = ($urandom_range(0, 15) != 0);
            d.fwait = $urandom_range(0, 3);
            d.awt   = $urandom_range(0, 2);
            d.mwait = $urandom_range(0, 3);
            d.sz    = 2'($urandom_range(0, 2));
            d.taken = 1'($urandom);
            if (d.kind == K_LOAD || d.kind == K_STORE) begin
                if ($urandom_range(0, 3) != 0)
                    d.res[1:0] = 2'b00;
            end else if (d.kind == K_JALR) begin
                d.res[1] = 1'b0;
            end
            run_instr(d, tr);
            if (tr)
                do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
